// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding, default width
// and the state decoder that folds the unused encoding back onto IDLE.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 32'sd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // The fourth encoding can only come from an upset, so recover to IDLE.
    function automatic state_e decode_state(input logic [1:0] raw);
        state_e st;
        case (raw)
            2'd1:    st = S_ADD;
            2'd2:    st = S_DONE;
            default: st = S_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the serial adder. The requester drives operands and
// start; the adder returns busy, the done pulse and the held result.
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/full_adder.sv
// Existing 1-bit full adder cell, reused as the bit-slice of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// WIDTH-bit adder built from one full_adder, one bit per clock, LSB first.
// The carry lives in a flop between bits; the result is held until the next completion.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 32'sd1);

    logic [1:0]       state_r;
    state_e           state_cur_s;
    state_e           state_next_s;
    logic             load_s;
    logic             step_s;
    logic             finish_s;

    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_next_s;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    logic             fa_s_s;
    logic             fa_cout_s;

    full_adder u_fa (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .cin  (carry_r),
        .s    (fa_s_s),
        .cout (fa_cout_s)
    );

    // Next-state and datapath control decode.
    always_comb begin
        state_cur_s  = decode_state(state_r);
        state_next_s = S_IDLE;
        load_s       = 1'b0;
        step_s       = 1'b0;
        finish_s     = 1'b0;
        case (state_cur_s)
            S_IDLE: begin
                if (bus.start) begin
                    state_next_s = S_ADD;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_ADD: begin
                step_s = 1'b1;
                if (cnt_r == LAST_BIT) begin
                    state_next_s = S_DONE;
                    finish_s     = 1'b1;
                end else begin
                    state_next_s = S_ADD;
                end
            end
            S_DONE: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // The new sum bit enters at the top so the LSB lands at bit 0 after WIDTH steps.
    always_comb begin
        acc_next_s = {fa_s_s, acc_r[WIDTH-1:1]};
    end

    // State register plus registered busy/done derived from the transition taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            // busy drops one bit early so it covers exactly WIDTH-1 cycles
            busy_r  <= (state_cur_s == S_ADD) && (state_next_s == S_ADD);
            done_r  <= (state_next_s == S_DONE);
        end
    end

    // Operand shift registers, carry flop, partial sum and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else if (load_s) begin
            a_sh_r  <= bus.a;
            b_sh_r  <= bus.b;
            acc_r   <= {WIDTH{1'b0}};
            carry_r <= bus.cin;
            cnt_r   <= {CW{1'b0}};
        end else if (step_s) begin
            a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
            b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
            acc_r   <= acc_next_s;
            carry_r <= fa_cout_s;
            // park the counter at zero on the last bit rather than let it run past WIDTH-1
            cnt_r   <= finish_s ? {CW{1'b0}} : cnt_r + CW'(1'b1);
        end
    end

    // Result registers only move on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r  <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
        end else if (finish_s) begin
            sum_r  <= acc_next_s;
            cout_r <= fa_cout_s;
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 2, 8 and 16, with a plain
// a+b+cin reference model and a done-pulse scoreboard.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(2))  i2 ();
    serial_adder_if #(.WIDTH(8))  i8 ();
    serial_adder_if #(.WIDTH(16)) i16 ();

    serial_adder #(.WIDTH(2))  u2  (.clk(clk), .rst(rst), .bus(i2));
    serial_adder #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(i8));
    serial_adder #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(i16));

    int vectors     = 0;
    int miscompares = 0;
    int dn2 = 0, dn8 = 0, dn16 = 0;

    // count every done pulse seen on each instance
    always @(negedge clk) begin
        if (i2.done === 1'b1)  dn2  <= dn2 + 1;
        if (i8.done === 1'b1)  dn8  <= dn8 + 1;
        if (i16.done === 1'b1) dn16 <= dn16 + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input int w, input logic st, input logic [15:0] av, input logic [15:0] bv, input logic c);
        case (w)
            2:       begin i2.start = st;  i2.a = av[1:0];  i2.b = bv[1:0];  i2.cin = c;  end
            8:       begin i8.start = st;  i8.a = av[7:0];  i8.b = bv[7:0];  i8.cin = c;  end
            default: begin i16.start = st; i16.a = av;      i16.b = bv;      i16.cin = c; end
        endcase
    endtask

    function automatic logic [16:0] get_res(input int w);
        case (w)
            2:       return {14'd0, i2.cout, i2.sum};
            8:       return {8'd0, i8.cout, i8.sum};
            default: return {i16.cout, i16.sum};
        endcase
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            2:       return i2.done;
            8:       return i8.done;
            default: return i16.done;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            2:       return i2.busy;
            8:       return i8.busy;
            default: return i16.busy;
        endcase
    endfunction

    function automatic int get_dn(input int w);
        case (w)
            2:       return dn2;
            8:       return dn8;
            default: return dn16;
        endcase
    endfunction

    // One operation: start at a negedge, then watch until done (bounded).
    // With junk set, random start/operands are driven while the adder is busy or done.
    task automatic run_op(input int w, input logic [15:0] av, input logic [15:0] bv, input logic c,
                          input bit junk, output int lat, output int busyc,
                          output logic [16:0] res, output bit stable);
        logic [16:0] prev;
        @(negedge clk);
        prev = get_res(w);
        drive(w, 1'b1, av, bv, c);
        @(negedge clk);
        lat    = -1;
        busyc  = 0;
        stable = 1'b1;
        for (int n = 0; n <= 4 * w + 8; n++) begin
            if (get_done(w) === 1'b1) begin
                lat = n;
                break;
            end
            if (get_busy(w) === 1'b1) busyc++;
            if (get_res(w) !== prev) stable = 1'b0;
            if (junk) drive(w, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            else      drive(w, 1'b0, 16'h0000, 16'h0000, 1'b0);
            @(negedge clk);
        end
        res = get_res(w);
        if (junk) drive(w, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        @(negedge clk);
        drive(w, 1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic test_reset();
        drive(2, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(16, 1'b0, 16'h0, 16'h0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            int w;
            w = (k == 0) ? 2 : (k == 1) ? 8 : 16;
            vectors++;
            if (get_busy(w) !== 1'b0 || get_done(w) !== 1'b0 || get_res(w) !== 17'd0) begin
                miscompares++;
                $display("FAIL reset_w%0d: busy=%b done=%b res=%h, want 0/0/0", w, get_busy(w), get_done(w), get_res(w));
            end
        end
    endtask

    task automatic test_directed();
        logic [15:0] ta [5] = '{16'h00, 16'hFF, 16'h3C, 16'hA5, 16'h80};
        logic [15:0] tb [5] = '{16'h00, 16'h01, 16'h42, 16'h5A, 16'h80};
        logic        tc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [16:0] te [5] = '{17'h000, 17'h100, 17'h07E, 17'h100, 17'h101};
        int lat, busyc;
        logic [16:0] res;
        bit stable;
        for (int i = 0; i < 5; i++) begin
            run_op(8, ta[i], tb[i], tc[i], 1'b0, lat, busyc, res, stable);
            vectors++;
            if (res !== te[i]) begin
                miscompares++;
                $display("FAIL directed_%0d_sum: got %h want %h", i, res, te[i]);
            end
            vectors++;
            if (lat != 8 || busyc != 7) begin
                miscompares++;
                $display("FAIL directed_%0d_timing: latency %0d busy %0d, want 8 and 7", i, lat, busyc);
            end
        end
    endtask

    task automatic test_start_ignored();
        int n1, n2, d0;
        logic [16:0] r1;
        @(negedge clk);
        #1 d0 = dn8;
        drive(8, 1'b1, 16'h01, 16'h02, 1'b0);
        @(negedge clk);
        drive(8, 1'b1, 16'h11, 16'h22, 1'b0);
        n1 = -1;
        for (int n = 0; n < 40; n++) begin
            if (i8.done === 1'b1) begin n1 = n; break; end
            @(negedge clk);
        end
        r1 = get_res(8);
        vectors++;
        if (n1 != 8 || r1 !== 17'h003) begin
            miscompares++;
            $display("FAIL start_ignored_first: latency %0d res %h, want 8 and 003", n1, r1);
        end
        n2 = -1;
        for (int n = 1; n < 40; n++) begin
            @(negedge clk);
            if (i8.done === 1'b1) begin n2 = n; break; end
        end
        drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
        vectors++;
        if (n2 != 10 || get_res(8) !== 17'h033) begin
            miscompares++;
            $display("FAIL start_held_second: gap %0d res %h, want 10 and 033", n2, get_res(8));
        end
        @(negedge clk);
        #1;
        vectors++;
        if (dn8 - d0 != 2) begin
            miscompares++;
            $display("FAIL start_ignored_count: %0d done pulses, want 2", dn8 - d0);
        end
    endtask

    task automatic test_reset_mid_add();
        int d0, lat, busyc;
        logic [16:0] res;
        bit stable;
        @(negedge clk);
        #1 d0 = dn8;
        drive(8, 1'b1, 16'hF0, 16'h0F, 1'b0);
        @(negedge clk);
        drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (i8.busy !== 1'b0 || i8.done !== 1'b0 || get_res(8) !== 17'd0) begin
            miscompares++;
            $display("FAIL reset_mid_add: busy=%b done=%b res=%h, want 0/0/0", i8.busy, i8.done, get_res(8));
        end
        repeat (12) @(negedge clk);
        #1;
        vectors++;
        if (dn8 != d0) begin
            miscompares++;
            $display("FAIL reset_mid_add_no_done: %0d done pulses, want 0", dn8 - d0);
        end
        run_op(8, 16'h12, 16'h34, 1'b1, 1'b0, lat, busyc, res, stable);
        vectors++;
        if (lat != 8 || res !== 17'h047) begin
            miscompares++;
            $display("FAIL after_reset_op: latency %0d res %h, want 8 and 047", lat, res);
        end
    endtask

    task automatic test_random(input int w);
        logic [16:0] mask, exp, res;
        logic [15:0] av, bv;
        logic c;
        int lat, busyc, d0, bad;
        bit stable;
        mask = (17'd1 << w) - 17'd1;
        @(negedge clk);
        #1 d0 = get_dn(w);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            av  = 16'($urandom) & mask[15:0];
            bv  = 16'($urandom) & mask[15:0];
            c   = 1'($urandom_range(0, 1));
            exp = 17'(av) + 17'(bv) + 17'(c);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(w, av, bv, c, 1'b1, lat, busyc, res, stable);
            vectors++;
            if (res !== exp || lat != w || busyc != w - 1 || !stable) begin
                miscompares++;
                if (bad < 10)
                    $display("FAIL random_w%0d #%0d: %h+%h+%0d gave %h lat %0d busy %0d stable %0d, want %h lat %0d busy %0d stable 1",
                             w, i, av, bv, c, res, lat, busyc, stable, exp, w, w - 1);
                bad++;
            end
        end
        @(negedge clk);
        #1;
        vectors++;
        if (get_dn(w) - d0 != 1000) begin
            miscompares++;
            $display("FAIL random_w%0d_done_count: %0d done pulses, want 1000", w, get_dn(w) - d0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_ignored();
        test_reset_mid_add();
        test_random(2);
        test_random(8);
        test_random(16);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
